// File: rtl/vc_output_buffer_pkg.sv
// Shared packet-layout constants for the ring router output stages.
// PKT_W          : packet width in bits
// HOP_MSB/HOP_LSB: bit range of the unsigned hop-count field
// vc_e           : virtual-channel identifier (VC_EVEN=0, VC_ODD=1)
package vc_output_buffer_pkg;

  localparam int PKT_W   = 64;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

endpackage

// File: rtl/vc_output_buffer_slot.sv
// One-entry virtual-channel buffer slot.
// clk, reset : clock, synchronous active-high reset
// wr_en      : capture wr_data (ignored while full)
// wr_data    : packet to store
// rd_en      : release the stored packet (ignored while empty)
// full       : slot holds a packet
// data       : stored packet
module vc_slot #(
  parameter int W = vc_output_buffer_pkg::PKT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         full,
  output logic [W-1:0] data
);

  import vc_output_buffer_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_en && !full) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (rd_en && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/vc_output_buffer.sv
// Output buffer of a ring router port, downstream of the rotating prioritizer.
// The granted input packet is written into the VC slot matching polarity while
// the opposite VC slot drains to the link with its hop field decremented.
// clk, reset        : clock, synchronous active-high reset
// polarity          : cycle phase (1 = odd, 0 = even), toggles every cycle
// gt0, gt1          : grants to input 0 / input 1
// din0, din1        : packets from input 0 / input 1
// ri                : downstream ready
// ro_even, ro_odd   : even / odd slot empty
// so, dout          : registered send-out valid and packet
module vc_output_buffer #(
  parameter int PKT_W   = vc_output_buffer_pkg::PKT_W,
  parameter int HOP_MSB = vc_output_buffer_pkg::HOP_MSB,
  parameter int HOP_LSB = vc_output_buffer_pkg::HOP_LSB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic             gt0,
  input  logic             gt1,
  input  logic [PKT_W-1:0] din0,
  input  logic [PKT_W-1:0] din1,
  input  logic             ri,
  output logic             ro_even,
  output logic             ro_odd,
  output logic             so,
  output logic [PKT_W-1:0] dout
);

  import vc_output_buffer_pkg::*;

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

  vc_e              wr_vc;
  logic             wr_any;
  logic [PKT_W-1:0] wr_data;
  logic             wr_even, wr_odd;
  logic             rd_even, rd_odd;
  logic             full_even, full_odd;
  logic [PKT_W-1:0] data_even, data_odd;
  logic [PKT_W-1:0] drain_pkt;
  logic [PKT_W-1:0] fwd_pkt;
  logic [HOP_W-1:0] hop;

  assign wr_vc   = vc_e'(polarity);
  assign wr_any  = gt0 | gt1;
  // din0 takes precedence if both grants are (illegally) asserted.
  assign wr_data = gt0 ? din0 : din1;

  assign wr_odd  = (wr_vc == VC_ODD)  && wr_any && !full_odd;
  assign wr_even = (wr_vc == VC_EVEN) && wr_any && !full_even;
  // The drained VC is always the one not being written this cycle.
  assign rd_even = (wr_vc == VC_ODD)  && full_even && ri;
  assign rd_odd  = (wr_vc == VC_EVEN) && full_odd  && ri;

  vc_slot #(.W(PKT_W)) u_slot_even (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_even),
    .wr_data (wr_data),
    .rd_en   (rd_even),
    .full    (full_even),
    .data    (data_even)
  );

  vc_slot #(.W(PKT_W)) u_slot_odd (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_odd),
    .wr_data (wr_data),
    .rd_en   (rd_odd),
    .full    (full_odd),
    .data    (data_odd)
  );

  assign ro_even = ~full_even;
  assign ro_odd  = ~full_odd;

  // Hop field is unsigned and saturates at zero.
  always_comb begin
    drain_pkt = (wr_vc == VC_ODD) ? data_even : data_odd;
    hop       = drain_pkt[HOP_MSB:HOP_LSB];
    fwd_pkt   = drain_pkt;
    if (hop != '0) begin
      fwd_pkt[HOP_MSB:HOP_LSB] = hop - HOP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      so   <= 1'b0;
      dout <= '0;
    end else if (rd_even || rd_odd) begin
      so   <= 1'b1;
      dout <= fwd_pkt;
    end else begin
      so   <= 1'b0;
    end
  end

endmodule
